ysyx_220578_seq_ctrl: RTL and testbench

Multi-cycle sequencer for the ysyx_220578 NPC core. It owns the PC and instruction registers, fetches each instruction over a valid/ready instruction-memory handshake, and steps the decode, execute, memory and writeback datapath one stage at a time. It raises stage enables and the register-file write strobe, and halts on `ebreak` or a misaligned next PC.

---
 rtl/ysyx_220578_seq_ctrl_if.sv | 33 +++
 rtl/ysyx_220578_seq_ctrl.sv | 151 +++++++++++++++
 tb/tb_ysyx_220578_seq_ctrl.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_220578_seq_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ysyx_220578_seq_ctrl_if : imem/dmem request-response bundle        |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface ysyx_220578_seq_ctrl_if #(
  parameter int PC_WIDTH   = 64,
  parameter int INST_WIDTH = 32
);
  logic                  imem_req_valid;
  logic [PC_WIDTH-1:0]   imem_req_addr;
  logic                  imem_req_ready;
  logic                  imem_rsp_valid;
  logic [INST_WIDTH-1:0] imem_rsp_inst;
  logic                  dmem_req_valid;
  logic                  dmem_req_ready;
  logic                  dmem_rsp_valid;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_inst,
    output dmem_req_valid,
    input  dmem_req_ready, dmem_rsp_valid
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_inst,
    input  dmem_req_valid,
    output dmem_req_ready, dmem_rsp_valid
  );
endinterface
`default_nettype wire

// File: rtl/ysyx_220578_seq_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ysyx_220578_seq_ctrl : multi-cycle fetch/decode/exec/mem/wb FSM    |
// | Optional perf counters: YSYX_220578_PERF_CNT_EN      Rev 1.0       |
// +--------------------------------------------------------------------+
module ysyx_220578_seq_ctrl #(
  parameter int                  PC_WIDTH   = 64,
  parameter int                  INST_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = PC_WIDTH'(64'h8000_0000)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  ysyx_220578_seq_ctrl_if.master bus,
  output logic [INST_WIDTH-1:0]  inst_q,
  output logic [PC_WIDTH-1:0]    pc_q,
  output logic                   exu_en,
  input  logic [PC_WIDTH-1:0]    dnpc_in,
  output logic                   rf_we,
  output logic                   halt,
  output logic [1:0]             halt_cause,
  output logic [2:0]             state_o,
  output logic [63:0]            perf_cycle,
  output logic [63:0]            perf_instret
);

  typedef enum logic [2:0] {
    S_FETCH_REQ  = 3'd0,
    S_FETCH_WAIT = 3'd1,
    S_DECODE     = 3'd2,
    S_EXEC       = 3'd3,
    S_MEM_REQ    = 3'd4,
    S_MEM_WAIT   = 3'd5,
    S_WB         = 3'd6,
    S_HALT       = 3'd7
  } state_e;

  localparam logic [6:0]            OPC_LOAD   = 7'b0000011;
  localparam logic [6:0]            OPC_STORE  = 7'b0100011;
  localparam logic [6:0]            OPC_BRANCH = 7'b1100011;
  localparam logic [INST_WIDTH-1:0] EBREAK     = INST_WIDTH'(32'h0010_0073);

  state_e                state_q, state_d;
  logic [INST_WIDTH-1:0] inst_d;
  logic [PC_WIDTH-1:0]   pc_d, npc_q, npc_d;
  logic [1:0]            halt_cause_q, halt_cause_d;
  logic [6:0]            opcode;
  logic                  is_mem, wb_writes, npc_misaligned;

  assign opcode         = inst_q[6:0];
  assign is_mem         = (opcode == OPC_LOAD) || (opcode == OPC_STORE);
  assign wb_writes      = (opcode != OPC_STORE) && (opcode != OPC_BRANCH) && (inst_q[11:7] != 5'd0);
  assign npc_misaligned = (npc_q[1:0] != 2'b00);

  always_comb begin
    state_d      = state_q;
    inst_d       = inst_q;
    pc_d         = pc_q;
    npc_d        = npc_q;
    halt_cause_d = halt_cause_q;
    case (state_q)
      S_FETCH_REQ:  if (bus.imem_req_ready) state_d = S_FETCH_WAIT;
      S_FETCH_WAIT: begin
        if (bus.imem_rsp_valid) begin
          inst_d  = bus.imem_rsp_inst;
          state_d = S_DECODE;
        end
      end
      S_DECODE:     state_d = S_EXEC;
      S_EXEC: begin
        npc_d = dnpc_in;
        if (inst_q == EBREAK) begin
          state_d      = S_HALT;
          halt_cause_d = 2'd1;
        end else if (is_mem) begin
          state_d = S_MEM_REQ;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM_REQ:    if (bus.dmem_req_ready) state_d = S_MEM_WAIT;
      S_MEM_WAIT:   if (bus.dmem_rsp_valid) state_d = S_WB;
      S_WB: begin
        // A misaligned target stops the core with pc_q still naming the culprit.
        if (npc_misaligned) begin
          state_d      = S_HALT;
          halt_cause_d = 2'd2;
        end else begin
          pc_d    = npc_q;
          state_d = S_FETCH_REQ;
        end
      end
      S_HALT:       state_d = S_HALT;
      default:      state_d = S_FETCH_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_FETCH_REQ;
      pc_q         <= RESET_PC;
      inst_q       <= '0;
      npc_q        <= '0;
      halt_cause_q <= 2'd0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      npc_q        <= npc_d;
      halt_cause_q <= halt_cause_d;
    end
  end

  // Strobes are masked by rst_n so nothing leaks out while reset is held.
  assign bus.imem_req_valid = rst_n && (state_q == S_FETCH_REQ);
  assign bus.imem_req_addr  = pc_q;
  assign bus.dmem_req_valid = rst_n && (state_q == S_MEM_REQ);
  assign exu_en             = rst_n && (state_q == S_EXEC);
  assign rf_we              = rst_n && (state_q == S_WB) && wb_writes;
  assign halt               = (state_q == S_HALT);
  assign halt_cause         = halt_cause_q;
  assign state_o            = state_q;

`ifdef YSYX_220578_PERF_CNT_EN
  logic [63:0] perf_cycle_q, perf_cycle_d, perf_instret_q, perf_instret_d;

  always_comb begin
    perf_cycle_d   = perf_cycle_q;
    perf_instret_d = perf_instret_q;
    if (state_q != S_HALT) perf_cycle_d = perf_cycle_q + 64'd1;
    if ((state_q == S_WB) && !npc_misaligned) perf_instret_d = perf_instret_q + 64'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_cycle_q   <= '0;
      perf_instret_q <= '0;
    end else begin
      perf_cycle_q   <= perf_cycle_d;
      perf_instret_q <= perf_instret_d;
    end
  end

  assign perf_cycle   = perf_cycle_q;
  assign perf_instret = perf_instret_q;
`else
  assign perf_cycle   = 64'd0;
  assign perf_instret = 64'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ysyx_220578_seq_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_ysyx_220578_seq_ctrl : directed bench with per-cycle model      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_ysyx_220578_seq_ctrl;
  localparam logic [63:0] RST_PC = 64'h8000_0000;
  localparam logic [31:0] EBRK   = 32'h0010_0073;
  localparam logic [31:0] ADDI1  = 32'h0050_0093;
  localparam logic [31:0] ADDI2  = 32'h00a0_0113;
  localparam logic [31:0] BEQ    = 32'h0000_0063;
  localparam logic [31:0] SW     = 32'h0011_2023;
  localparam logic [31:0] LW     = 32'h0000_a183;

  logic        clk, rst_n;
  logic [31:0] inst_q;
  logic [63:0] pc_q, dnpc_in, perf_cycle, perf_instret;
  logic        exu_en, rf_we, halt;
  logic [1:0]  halt_cause;
  logic [2:0]  state_o;
  int          n_tests, n_fail;

  ysyx_220578_seq_ctrl_if #(.PC_WIDTH(64), .INST_WIDTH(32)) bus ();

  ysyx_220578_seq_ctrl #(.PC_WIDTH(64), .INST_WIDTH(32), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .inst_q(inst_q), .pc_q(pc_q),
    .exu_en(exu_en), .dnpc_in(dnpc_in), .rf_we(rf_we), .halt(halt),
    .halt_cause(halt_cause), .state_o(state_o),
    .perf_cycle(perf_cycle), .perf_instret(perf_instret)
  );

  initial begin clk = 1'b0; forever #5 clk = ~clk; end

  // Program table: instruction, next-PC offset, dmem ready stall cycles.
  logic [31:0] p_inst [0:7];
  int          p_off  [0:7];
  int          p_stall[0:7];
  int          p_len;

  function automatic logic [31:0] get_inst(int i);
    return (i < p_len && i < 8) ? p_inst[i] : EBRK;
  endfunction
  function automatic int get_off(int i);
    return (i < p_len && i < 8) ? p_off[i] : 4;
  endfunction
  function automatic int get_stall(int i);
    return (i < p_len && i < 8) ? p_stall[i] : 0;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory responder: imem always ready, response one cycle after the handshake.
  int          f_idx, d_left;
  bit          i_pend, d_pend;
  logic [31:0] cur_inst;
  initial begin
    bus.imem_req_ready = 1'b1; bus.imem_rsp_valid = 1'b0; bus.imem_rsp_inst = '0;
    bus.dmem_req_ready = 1'b0; bus.dmem_rsp_valid = 1'b0;
    dnpc_in = '0; f_idx = 0; d_left = 0; i_pend = 0; d_pend = 0; cur_inst = '0;
    forever begin
      @(negedge clk); #1;
      bus.imem_rsp_valid = i_pend;
      bus.imem_rsp_inst  = i_pend ? cur_inst : 32'h0;
      bus.dmem_rsp_valid = d_pend;
      if (bus.dmem_req_valid) begin
        bus.dmem_req_ready = (d_left == 0);
        if (d_left > 0) d_left--;
      end else begin
        bus.dmem_req_ready = 1'b0;
      end
      #3;
      if (!rst_n) begin
        i_pend = 0; d_pend = 0; f_idx = 0; d_left = 0;
      end else begin
        i_pend = bus.imem_req_valid && bus.imem_req_ready;
        d_pend = bus.dmem_req_valid && bus.dmem_req_ready;
        if (i_pend) begin
          cur_inst = get_inst(f_idx);
          dnpc_in  = bus.imem_req_addr + 64'(get_off(f_idx));
          d_left   = get_stall(f_idx);
          f_idx++;
        end
      end
    end
  end

  // Model: position k within the current instruction's cycle timeline.
  int          m_k, m_idx, m_stall;
  logic [63:0] m_pc, m_dnpc, m_cyc, m_ret;
  logic [31:0] m_inst;
  bit          m_halt;
  logic [1:0]  m_cause;

  function automatic bit op_mem(input logic [31:0] i);
    return (i[6:0] == 7'b0000011) || (i[6:0] == 7'b0100011);
  endfunction
  function automatic bit op_writes(input logic [31:0] i);
    return (i[6:0] != 7'b0100011) && (i[6:0] != 7'b1100011) && (i[11:7] != 5'd0);
  endfunction

  initial begin
    bit          mem, wr;
    int          wb;
    logic [2:0]  es;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        m_k = 0; m_idx = 0; m_stall = 0; m_pc = RST_PC; m_dnpc = '0; m_inst = '0;
        m_halt = 0; m_cause = 0; m_cyc = 0; m_ret = 0;
        chk("rst_imem_valid", bus.imem_req_valid, 0);
        chk("rst_dmem_valid", bus.dmem_req_valid, 0);
        chk("rst_exu_en", exu_en, 0);
        chk("rst_rf_we", rf_we, 0);
        chk("rst_state", state_o, 0);
        chk("rst_pc", pc_q, RST_PC);
        chk("rst_inst", inst_q, 0);
        chk("rst_halt", {halt, halt_cause}, 0);
        chk("rst_perf", perf_cycle | perf_instret, 0);
      end else begin
        mem = op_mem(m_inst);
        wb  = mem ? 6 + m_stall : 4;
        if (!m_halt) begin
          m_cyc++;
          if (m_k == 0) begin
            m_inst = get_inst(m_idx); m_dnpc = m_pc + 64'(get_off(m_idx));
            m_stall = get_stall(m_idx); m_idx++; m_k = 1;
          end else if (m_k == 3 && m_inst == EBRK) begin
            m_halt = 1; m_cause = 2'd1;
          end else if (m_k == wb) begin
            if (m_dnpc[1:0] != 2'b00) begin m_halt = 1; m_cause = 2'd2; end
            else begin m_pc = m_dnpc; m_k = 0; m_ret++; end
          end else begin
            m_k++;
          end
        end
        mem = op_mem(m_inst);
        wr  = op_writes(m_inst);
        wb  = mem ? 6 + m_stall : 4;
        if (m_halt)                             es = 3'd7;
        else if (m_k <= 3)                      es = 3'(m_k);
        else if (mem && m_k <= 4 + m_stall)     es = 3'd4;
        else if (mem && m_k == 5 + m_stall)     es = 3'd5;
        else                                    es = 3'd6;
        chk("imem_valid", bus.imem_req_valid, !m_halt && m_k == 0);
        chk("imem_addr", bus.imem_req_addr, m_pc);
        chk("exu_en", exu_en, !m_halt && m_k == 3);
        chk("dmem_valid", bus.dmem_req_valid, !m_halt && mem && m_k >= 4 && m_k <= 4 + m_stall);
        chk("rf_we", rf_we, !m_halt && m_k == wb && wr);
        chk("halt", halt, m_halt);
        chk("halt_cause", halt_cause, m_cause);
        chk("state", state_o, es);
        chk("pc", pc_q, m_pc);
        if (m_halt || m_k >= 2) chk("inst", inst_q, m_inst);
`ifdef YSYX_220578_PERF_CNT_EN
        chk("perf_cycle", perf_cycle, m_cyc);
        chk("perf_instret", perf_instret, m_ret);
`else
        chk("perf_tied", perf_cycle | perf_instret, 0);
`endif
      end
    end
  end

  // Leaves the bench at negedge+2 of cycle 0, the first cycle with rst_n high.
  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("reset_state", state_o, 0);
    chk("reset_pc", pc_q, RST_PC);
    chk("reset_req", bus.imem_req_valid, 0);
    @(negedge clk); rst_n = 1'b1;
    #2;
  endtask

  task automatic next_cycle();
    @(posedge clk); #2;
  endtask

  initial begin
    int dv_cnt, rf_cnt;
    rst_n = 1'b0; n_tests = 0; n_fail = 0; p_len = 0;

    // Three non-memory instructions then ebreak.
    p_len = 3;
    p_inst[0] = ADDI1; p_off[0] = 4; p_stall[0] = 0;
    p_inst[1] = BEQ;   p_off[1] = 4; p_stall[1] = 0;
    p_inst[2] = ADDI2; p_off[2] = 4; p_stall[2] = 0;
    do_reset();
    chk("first_req_c0", bus.imem_req_valid, 1);
    for (int c = 1; c <= 25; c++) begin
      next_cycle();
      if (c == 3) chk("addi_exu_c3", exu_en, 1);
      if (c == 4) chk("addi_rfwe_c4", rf_we, 1);
      if (c == 5) chk("addi_pc_c5", pc_q, 64'h8000_0004);
      if (c == 9) chk("beq_no_rfwe", rf_we, 0);
      if (c == 15) begin
`ifdef YSYX_220578_PERF_CNT_EN
        chk("perf_instret_3", perf_instret, 3);
        chk("perf_cycle_15", perf_cycle, 15);
`else
        chk("perf_off_zero", perf_cycle, 0);
`endif
      end
      if (c == 19) chk("t1_ebreak_halt", {halt, halt_cause}, 3'b101);
    end

    // Store with dmem ready low for three cycles, then a load.
    p_len = 2;
    p_inst[0] = SW; p_off[0] = 4; p_stall[0] = 3;
    p_inst[1] = LW; p_off[1] = 4; p_stall[1] = 0;
    do_reset();
    dv_cnt = 0; rf_cnt = 0;
    for (int c = 1; c <= 25; c++) begin
      next_cycle();
      if (c <= 9) begin
        dv_cnt += int'(bus.dmem_req_valid);
        rf_cnt += int'(rf_we);
      end
      if (c == 9)  chk("store_pc_c9", pc_q, RST_PC);
      if (c == 10) chk("store_pc_c10", pc_q, RST_PC + 64'd4);
      if (c == 10) chk("store_next_req", bus.imem_req_valid, 1);
      if (c == 16) chk("load_rfwe_c16", rf_we, 1);
    end
    chk("store_dmem_valid_cycles", 64'(dv_cnt), 4);
    chk("store_rfwe_count", 64'(rf_cnt), 0);

    // Bare ebreak.
    p_len = 0;
    do_reset();
    for (int c = 1; c <= 12; c++) begin
      next_cycle();
      if (c == 3) chk("ebreak_exu_c3", exu_en, 1);
      if (c == 3) chk("ebreak_not_yet", halt, 0);
      if (c >= 4) chk("ebreak_halt", {halt, halt_cause}, 3'b101);
      if (c >= 4) chk("ebreak_no_fetch", bus.imem_req_valid, 0);
    end

    // Misaligned next PC.
    p_len = 1;
    p_inst[0] = ADDI1; p_off[0] = 6; p_stall[0] = 0;
    do_reset();
    for (int c = 1; c <= 8; c++) begin
      next_cycle();
      if (c == 5) chk("misalign_cause", {halt, halt_cause}, 3'b110);
      if (c == 5) chk("misalign_pc_kept", pc_q, RST_PC);
    end

    // Reset while waiting on a load response.
    p_len = 1;
    p_inst[0] = LW; p_off[0] = 4; p_stall[0] = 0;
    do_reset();
    for (int c = 1; c <= 5; c++) next_cycle();
    chk("midrst_in_mem_wait", state_o, 5);
    @(negedge clk); rst_n = 1'b0;
    next_cycle();
    chk("midrst_state", state_o, 0);
    chk("midrst_pc", pc_q, RST_PC);
    chk("midrst_no_rfwe", rf_we, 0);
    next_cycle();
    chk("midrst_no_rfwe_2", rf_we, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (6) next_cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
